// File: rtl/relu_maxpool_strip.sv
// ReLU followed by 2x2 stride-2 max-pool over one conv output strip.
// Streams four taps per window from the conv memory and writes one 8-bit pooled value.
module relu_maxpool_strip #(
    parameter int CONV_W = 222,
    parameter int CONV_H = 26,
    parameter int IN_W   = 9,
    parameter int OUT_W  = 8,
    parameter int RD_LAT = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   conv_done,
    output logic [15:0]            rd_addr,
    input  logic signed [IN_W-1:0] rd_data,
    output logic                   wr_en,
    output logic [15:0]            wr_addr,
    output logic [OUT_W-1:0]       wr_data,
    output logic                   busy,
    output logic                   done
);

    localparam int PW = CONV_W / 2;
    localparam int PH = CONV_H / 2;
    localparam logic [15:0] ROW_STEP   = 16'(2 * CONV_W);
    localparam logic [15:0] PC_LAST    = 16'(PW - 1);
    localparam logic [15:0] PR_LAST    = 16'(PH - 1);
    localparam logic [7:0]  DRAIN_LAST = 8'(RD_LAT - 1);

    typedef enum logic [2:0] {IDLE, FETCH, DRAIN, WRITE, DONE} state_t;

    state_t state, state_nxt;

    logic [1:0]  tap;
    logic [7:0]  drain_cnt;
    logic [15:0] pc;
    logic [15:0] pr;
    logic [15:0] row_base;
    logic [15:0] out_idx;
    logic [15:0] tap_off;
    logic [15:0] tap_addr;
    logic        launch;
    logic        last_win;

    // Bit 0 marks a tap address on rd_addr; bit RD_LAT marks its data on rd_data.
    logic [RD_LAT:0]        vld_pipe;
    logic signed [IN_W-1:0] max_acc;
    logic signed [IN_W-1:0] max_nxt;

    function automatic logic signed [IN_W-1:0] smax(input logic signed [IN_W-1:0] a,
                                                     input logic signed [IN_W-1:0] b);
        return (b > a) ? b : a;
    endfunction

    function automatic logic [OUT_W-1:0] sat_out(input logic signed [IN_W-1:0] v);
        if (int'(v) < 0)
            return '0;
        if (int'(v) > (1 << OUT_W) - 1)
            return '1;
        return OUT_W'(v);
    endfunction

    always_comb begin
        launch   = start && conv_done;
        last_win = (pr == PR_LAST) && (pc == PC_LAST);
        busy     = (state == FETCH) || (state == DRAIN) || (state == WRITE);

        case (tap)
            2'd0:    tap_off = 16'd0;
            2'd1:    tap_off = 16'd1;
            2'd2:    tap_off = 16'(CONV_W);
            default: tap_off = 16'(CONV_W + 1);
        endcase
        tap_addr = row_base + (pc << 1) + tap_off;

        // Running max starts at zero, so negative taps never win: that is the ReLU.
        max_nxt = vld_pipe[RD_LAT] ? smax(max_acc, rd_data) : max_acc;

        state_nxt = state;
        case (state)
            IDLE:    if (launch) state_nxt = FETCH;
            FETCH:   if (tap == 2'd3) state_nxt = DRAIN;
            DRAIN:   if (drain_cnt == DRAIN_LAST) state_nxt = WRITE;
            WRITE:   state_nxt = last_win ? DONE : FETCH;
            DONE:    if (launch) state_nxt = FETCH;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            tap       <= '0;
            drain_cnt <= '0;
            pc        <= '0;
            pr        <= '0;
            row_base  <= '0;
            out_idx   <= '0;
            vld_pipe  <= '0;
            max_acc   <= '0;
            rd_addr   <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            vld_pipe  <= {vld_pipe[RD_LAT-1:0], (state == FETCH)};
            wr_en     <= (state == WRITE);
            drain_cnt <= (state == DRAIN) ? drain_cnt + 8'd1 : 8'd0;

            if (state == FETCH) begin
                rd_addr <= tap_addr;
                tap     <= tap + 2'd1;
            end

            // The last tap arrives in the WRITE cycle, so the output takes max_nxt.
            if (state == WRITE) begin
                wr_addr <= out_idx;
                wr_data <= sat_out(max_nxt);
                max_acc <= '0;
                out_idx <= out_idx + 16'd1;
                if (pc == PC_LAST) begin
                    pc       <= '0;
                    pr       <= pr + 16'd1;
                    row_base <= row_base + ROW_STEP;
                end else begin
                    pc <= pc + 16'd1;
                end
            end else begin
                max_acc <= max_nxt;
            end

            if (((state == IDLE) || (state == DONE)) && launch) begin
                tap      <= '0;
                pc       <= '0;
                pr       <= '0;
                row_base <= '0;
                out_idx  <= '0;
                max_acc  <= '0;
            end

            if (state == DONE)
                done <= !launch;
        end
    end

endmodule

// File: doc/relu_maxpool_strip.md
Name: relu_maxpool_strip

Overview:
- Downstream stage of the 3x3 im2col convolution unit for one horizontal strip.
- Starts once the conv unit raises done. Reads the strip's conv result memory (CONV_W x CONV_H, row-major, 9-bit signed), applies ReLU and 2x2 stride-2 max-pool, and writes 8-bit unsigned pooled values to the pooled-strip memory.
- One instance per strip; the memory read port is owned by this block once started.

Parameters:
- CONV_W, 222, conv output columns per strip (224-3+1)
- CONV_H, 26, conv output rows per strip (28-3+1)
- IN_W, 9, conv result width, signed
- OUT_W, 8, pooled output width, unsigned
- RD_LAT, 1, conv memory read latency in cycles (BRAM douta)

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  request to pool the strip
- conv_done  in  1  conv unit has finished the strip
- rd_addr  out  16  conv result memory address
- rd_data  in  9  conv result memory data, signed, valid RD_LAT cycles after rd_addr
- wr_en  out  1  pooled memory write strobe
- wr_addr  out  16  pooled memory address
- wr_data  out  8  pooled value
- busy  out  1  high from FETCH through WRITE of the last window
- done  out  1  strip pooled; sticky

Behaviour:
- Reset (async, reset=0): all outputs 0, FSM=IDLE, window row/col counters 0, running max 0.
- Pooled geometry: PW=floor(CONV_W/2), PH=floor(CONV_H/2). Defaults give 111x13 = 1443 outputs. An odd last column or row is never read.
- FSM states: IDLE, FETCH, DRAIN, WRITE, DONE.
- IDLE:
  - Leaves only when start&&conv_done is sampled high; goes to FETCH.
  - start without conv_done is ignored, with no reads.
- FETCH (4 cycles, tap t=0..3):
  - rd_addr = base+{0, 1, CONV_W, CONV_W+1}[t], where base = 2*pr*CONV_W + 2*pc.
  - Registered; a new address is issued every cycle.
- Capture:
  - rd_data for tap t is captured RD_LAT cycles after that tap is issued.
  - Running max starts at 0 per window; max = (rd_data>max) ? rd_data : max, signed compare.
  - The 0 initial value implements ReLU.
- DRAIN: RD_LAT cycles while the last taps return.
- WRITE (1 cycle):
  - wr_en=1, wr_addr = pr*PW+pc, wr_data = max[7:0]. This is lossless: max is in 0..255.
  - wr_en is 0 in every other cycle.
  - Then pc++. On pc==PW-1: pc=0, pr++. On the last window (pr==PH-1, pc==PW-1) go to DONE; otherwise return to FETCH.
- Throughput: 4+RD_LAT+1 cycles per output, which is 6 at default settings.
- Timing: start sampled at edge 0 → first rd_addr valid after edge 1 → first wr_en at cycle 6 → done=1 after edge 1443*6+1 = 8659.
- busy = (FSM in FETCH, DRAIN or WRITE).
- DONE:
  - done=1 and held. rd_addr holds its last value.
  - A new start&&conv_done clears done on the next edge, resets pr/pc to 0 and enters FETCH. This re-pools the strip.
- start while busy: ignored, with no restart.
- conv_done dropping mid-operation: ignored.
- Reset mid-operation: immediate abort. No further writes; the partial window is discarded.
- rd_data X outside capture cycles must not affect max.

Test Plan:
1. CONV_W=4, CONV_H=2, memory {3,7,0,0 / 5,1,0,0}; start&&conv_done → exactly 2 writes: (addr0,7), (addr1,0). done=1 on the cycle after the second WRITE.
2. Window {-5,-1,-200,-3} → wr_data 0. Window {-256,255,0,-1} → wr_data 255 (signed compare, no wrap).
3. start=1, conv_done=0 held 20 cycles → busy=0, rd_addr static, no wr_en. Raising conv_done then starts FETCH on the next edge.
4. Default parameters, rd_data = (addr mod 200)-100 via a BRAM model with RD_LAT=1 → 1443 writes, wr_addr 0..1442 in order, each checked against the reference model. done rises 8659 cycles after start, wr_en period 6 cycles.
5. reset driven low in the middle of window 500 → all outputs 0 in the same cycle with no clock edge. A restart after release produces the full sequence from wr_addr 0.
6. CONV_W=5, CONV_H=3, RD_LAT=2 → 2 outputs. Column 4 and row 2 are never addressed. 7 cycles per output. A second start after done gives identical writes.
